// File: rtl/rd_part_arb.sv
// Splits one line fetch into three DDR read parts and steers data-valid strobes to the active part.
// Optional per-part watchdog enabled by defining RD_PART_ARB_TIMEOUT_EN.
module rd_part_arb #(
  parameter int unsigned ADDR_WIDTH = 27,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned TO_CYCLES  = 4096
) (
  input  logic                  ddr_clk,
  input  logic                  ddr_rst,
  input  logic                  line_req,
  input  logic [ADDR_WIDTH-1:0] part_raddr,
  input  logic [LEN_WIDTH-1:0]  part_rlen,
  output logic                  ctrl_rreq,
  output logic [ADDR_WIDTH-1:0] ctrl_raddr,
  output logic [LEN_WIDTH-1:0]  ctrl_rlen,
  input  logic                  ctrl_rrdy,
  input  logic                  ctrl_rdone,
  input  logic                  ctrl_rdata_en,
  output logic                  rd_opera_en_1,
  output logic                  rd_opera_en_2,
  output logic                  rdata_en1,
  output logic                  rdata_en2,
  output logic                  rdata_en3,
  output logic                  busy,
  output logic [1:0]            part_idx,
  output logic                  err_timeout
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_REQ  = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0] state_q;
  logic [2:0] state_nxt;
  logic [1:0] idx_nxt;
  logic       load_addr;
  logic       act_nxt;
  logic       part_done;
  logic       data_win;
  logic       to_fire;

  // A part completes on rdone in DATA, or on rrdy+rdone together in REQ
  assign part_done = ctrl_rdone && ((state_q == S_DATA) || ((state_q == S_REQ) && ctrl_rrdy));
  assign data_win  = (state_q == S_DATA) || ((state_q == S_REQ) && ctrl_rrdy);

  assign rdata_en1 = data_win && ctrl_rdata_en && (part_idx == 2'd0);
  assign rdata_en2 = data_win && ctrl_rdata_en && (part_idx == 2'd1);
  assign rdata_en3 = data_win && ctrl_rdata_en && (part_idx == 2'd2);

`ifdef RD_PART_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TO_CYCLES - 1);

  logic [CNT_W-1:0] to_cnt;
  logic             to_hit;

  assign to_hit  = (to_cnt == CNT_MAX) && ((state_q == S_REQ) || (state_q == S_DATA));
  assign to_fire = to_hit && !part_done;

  // Counter restarts for every part on the LOAD->REQ transition
  always_ff @(posedge ddr_clk or posedge ddr_rst) begin
    if (ddr_rst) begin
      to_cnt      <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (state_q == S_LOAD) begin
        to_cnt <= '0;
      end else if ((state_q == S_REQ) || (state_q == S_DATA)) begin
        to_cnt <= to_cnt + CNT_W'(1);
      end
      if (to_fire) begin
        err_timeout <= 1'b1;
      end
    end
  end
`else
  logic unused_to_cycles;
  assign unused_to_cycles = (TO_CYCLES == 0);
  assign to_fire          = 1'b0;
  assign err_timeout      = 1'b0;
`endif

  always_comb begin
    state_nxt = state_q;
    idx_nxt   = part_idx;
    load_addr = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (line_req) begin
          state_nxt = S_LOAD;
          idx_nxt   = 2'd0;
        end
      end
      S_LOAD: begin
        state_nxt = S_REQ;
        load_addr = 1'b1;
      end
      S_REQ, S_DATA: begin
        if (part_done) begin
          if (part_idx == 2'd2) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_LOAD;
            idx_nxt   = part_idx + 2'd1;
          end
        end else if (to_fire) begin
          state_nxt = S_DONE;
        end else if ((state_q == S_REQ) && ctrl_rrdy) begin
          state_nxt = S_DATA;
        end
      end
      S_DONE: begin
        if (!line_req) begin
          state_nxt = S_IDLE;
          idx_nxt   = 2'd0;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        idx_nxt   = 2'd0;
      end
    endcase
    act_nxt = (state_nxt == S_LOAD) || (state_nxt == S_REQ) || (state_nxt == S_DATA);
  end

  // Status outputs are registered from next-state so they line up with the state register
  always_ff @(posedge ddr_clk or posedge ddr_rst) begin
    if (ddr_rst) begin
      state_q       <= S_IDLE;
      part_idx      <= 2'd0;
      ctrl_rreq     <= 1'b0;
      ctrl_raddr    <= '0;
      ctrl_rlen     <= '0;
      rd_opera_en_1 <= 1'b0;
      rd_opera_en_2 <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state_q       <= state_nxt;
      part_idx      <= idx_nxt;
      ctrl_rreq     <= (state_nxt == S_REQ);
      rd_opera_en_1 <= act_nxt && (idx_nxt == 2'd0);
      rd_opera_en_2 <= act_nxt && (idx_nxt == 2'd1);
      busy          <= (state_nxt != S_IDLE);
      if (load_addr) begin
        ctrl_raddr <= part_raddr;
        ctrl_rlen  <= part_rlen;
      end
    end
  end

endmodule

// File: tb/tb_rd_part_arb.sv
// Bench for rd_part_arb: directed vector table, random run against a line-fetch model, timeout sequence.
module tb_rd_part_arb;

  localparam int unsigned AW = 27;
  localparam int unsigned LW = 16;
  localparam int unsigned TO = 8;
  localparam int unsigned OW = 10 + AW + LW;
`ifdef RD_PART_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
  localparam logic [2:0] LONG_WAIT_EXP = 3'b110;
`else
  localparam bit TO_EN = 1'b0;
  localparam logic [2:0] LONG_WAIT_EXP = 3'b011;
`endif

  logic          ddr_clk = 1'b0;
  logic          ddr_rst = 1'b1;
  logic          line_req = 1'b0;
  logic [AW-1:0] part_raddr = '0;
  logic [LW-1:0] part_rlen = '0;
  logic          ctrl_rrdy = 1'b0;
  logic          ctrl_rdone = 1'b0;
  logic          ctrl_rdata_en = 1'b0;
  logic          ctrl_rreq;
  logic [AW-1:0] ctrl_raddr;
  logic [LW-1:0] ctrl_rlen;
  logic          rd_opera_en_1, rd_opera_en_2;
  logic          rdata_en1, rdata_en2, rdata_en3;
  logic          busy;
  logic [1:0]    part_idx;
  logic          err_timeout;

  int n_pass = 0;
  int n_total = 0;

  always #5 ddr_clk = ~ddr_clk;

  rd_part_arb #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW), .TO_CYCLES(TO)) dut (
    .ddr_clk(ddr_clk), .ddr_rst(ddr_rst), .line_req(line_req),
    .part_raddr(part_raddr), .part_rlen(part_rlen),
    .ctrl_rreq(ctrl_rreq), .ctrl_raddr(ctrl_raddr), .ctrl_rlen(ctrl_rlen),
    .ctrl_rrdy(ctrl_rrdy), .ctrl_rdone(ctrl_rdone), .ctrl_rdata_en(ctrl_rdata_en),
    .rd_opera_en_1(rd_opera_en_1), .rd_opera_en_2(rd_opera_en_2),
    .rdata_en1(rdata_en1), .rdata_en2(rdata_en2), .rdata_en3(rdata_en3),
    .busy(busy), .part_idx(part_idx), .err_timeout(err_timeout)
  );

  logic [OW-1:0] got_v;
  assign got_v = {err_timeout, busy, ctrl_rreq, rd_opera_en_1, rd_opera_en_2,
                  rdata_en1, rdata_en2, rdata_en3, part_idx, ctrl_raddr, ctrl_rlen};

  typedef struct {
    string         name;
    logic          rst, lreq, rrdy, rdone, rde;
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    logic          busy, rreq;
    logic [1:0]    op;
    logic [2:0]    rden;
    logic [1:0]    idx;
    logic [AW-1:0] raddr;
    logic [LW-1:0] rlen;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(string n, logic rst, logic lreq, logic rrdy, logic rdone, logic rde,
                              logic [AW-1:0] a, logic [LW-1:0] l, logic b, logic rq,
                              logic [1:0] op, logic [2:0] rden, logic [1:0] idx,
                              logic [AW-1:0] ra, logic [LW-1:0] rl);
    vec_t v;
    v.name = n; v.rst = rst; v.lreq = lreq; v.rrdy = rrdy; v.rdone = rdone; v.rde = rde;
    v.addr = a; v.len = l; v.busy = b; v.rreq = rq; v.op = op; v.rden = rden; v.idx = idx;
    v.raddr = ra; v.rlen = rl;
    return v;
  endfunction

  task automatic chk(input string name, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%h exp=%h (err,busy,rreq,op1,op2,rd1,rd2,rd3,idx,raddr,rlen)",
                  name, got, exp);
  endtask

  task automatic drive(input logic rst, input logic lreq, input logic rrdy, input logic rdone,
                       input logic rde, input logic [AW-1:0] a, input logic [LW-1:0] l);
    ddr_rst = rst; line_req = lreq; ctrl_rrdy = rrdy; ctrl_rdone = rdone;
    ctrl_rdata_en = rde; part_raddr = a; part_rlen = l;
  endtask

  // Reference model: one line = three parts, each fetched, requested, then drained
  typedef enum int {M_IDLE, M_FETCH, M_ASK, M_XFER, M_HOLD} mph_t;
  mph_t          m_ph;
  int            m_part;
  int            m_wait;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_len;
  logic          m_err;

  function automatic void m_reset();
    m_ph = M_IDLE; m_part = 0; m_wait = 0; m_addr = '0; m_len = '0; m_err = 1'b0;
  endfunction

  function automatic void m_update();
    bit fin;
    case (m_ph)
      M_IDLE: if (line_req) begin m_ph = M_FETCH; m_part = 0; end
      M_FETCH: begin m_addr = part_raddr; m_len = part_rlen; m_ph = M_ASK; m_wait = 0; end
      M_ASK, M_XFER: begin
        fin = ctrl_rdone && (m_ph == M_XFER || ctrl_rrdy);
        if (TO_EN && !fin && m_wait == int'(TO) - 1) begin
          m_err = 1'b1; m_ph = M_HOLD;
        end else begin
          m_wait++;
          if (fin) begin
            if (m_part == 2) m_ph = M_HOLD;
            else begin m_part++; m_ph = M_FETCH; end
          end else if (m_ph == M_ASK && ctrl_rrdy) m_ph = M_XFER;
        end
      end
      default: if (!line_req) begin m_ph = M_IDLE; m_part = 0; end
    endcase
  endfunction

  function automatic logic [OW-1:0] m_exp();
    logic       act, win;
    logic [2:0] rd;
    act = (m_ph == M_FETCH) || (m_ph == M_ASK) || (m_ph == M_XFER);
    win = (m_ph == M_XFER) || (m_ph == M_ASK && ctrl_rrdy);
    rd = 3'b000;
    if (win && ctrl_rdata_en) rd = 3'b100 >> m_part;
    return {m_err, m_ph != M_IDLE, m_ph == M_ASK, act && m_part == 0, act && m_part == 1,
            rd, 2'(m_part), m_addr, m_len};
  endfunction

  task automatic mstep(input string name, input logic rst, input logic lreq, input logic rrdy,
                       input logic rdone, input logic rde, input logic [AW-1:0] a,
                       input logic [LW-1:0] l);
    drive(rst, lreq, rrdy, rdone, rde, a, l);
    if (ddr_rst) m_reset();
    #1;
    chk(name, got_v, m_exp());
    @(posedge ddr_clk);
    if (ddr_rst) m_reset();
    else m_update();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // name rst lreq rrdy rdone rde addr len | busy rreq op rden(1,2,3) idx raddr rlen
    tbl.push_back(mk("reset",          1,0,0,0,0, 27'h0,  16'h0,  0,0,2'b00,3'b000,2'd0, 27'h0,  16'h0));
    tbl.push_back(mk("idle_req",       0,1,0,0,0, 27'h100,16'h40, 0,0,2'b00,3'b000,2'd0, 27'h0,  16'h0));
    tbl.push_back(mk("load_p0",        0,1,0,0,1, 27'h100,16'h40, 1,0,2'b10,3'b000,2'd0, 27'h0,  16'h0));
    tbl.push_back(mk("req_p0_wait",    0,1,0,0,1, 27'h555,16'h77, 1,1,2'b10,3'b000,2'd0, 27'h100,16'h40));
    tbl.push_back(mk("req_p0_rrdy",    0,1,1,0,1, 27'h555,16'h77, 1,1,2'b10,3'b100,2'd0, 27'h100,16'h40));
    tbl.push_back(mk("data_p0",        0,1,0,0,1, 27'h555,16'h77, 1,0,2'b10,3'b100,2'd0, 27'h100,16'h40));
    tbl.push_back(mk("data_p0_done",   0,1,0,1,0, 27'h200,16'h20, 1,0,2'b10,3'b000,2'd0, 27'h100,16'h40));
    tbl.push_back(mk("load_p1",        0,1,0,0,0, 27'h200,16'h20, 1,0,2'b01,3'b000,2'd1, 27'h100,16'h40));
    tbl.push_back(mk("req_p1_rrdy",    0,1,1,0,0, 27'h200,16'h20, 1,1,2'b01,3'b000,2'd1, 27'h200,16'h20));
    tbl.push_back(mk("data_p1_de1",    0,1,0,0,1, 27'h200,16'h20, 1,0,2'b01,3'b010,2'd1, 27'h200,16'h20));
    tbl.push_back(mk("data_p1_de0",    0,1,0,0,0, 27'h200,16'h20, 1,0,2'b01,3'b000,2'd1, 27'h200,16'h20));
    tbl.push_back(mk("data_p1_done",   0,1,0,1,1, 27'h300,16'h10, 1,0,2'b01,3'b010,2'd1, 27'h200,16'h20));
    tbl.push_back(mk("load_p2",        0,1,0,0,0, 27'h300,16'h10, 1,0,2'b00,3'b000,2'd2, 27'h200,16'h20));
    tbl.push_back(mk("req_p2_both",    0,1,1,1,1, 27'h300,16'h10, 1,1,2'b00,3'b001,2'd2, 27'h300,16'h10));
    tbl.push_back(mk("done_hold",      0,1,0,0,1, 27'h300,16'h10, 1,0,2'b00,3'b000,2'd2, 27'h300,16'h10));
    tbl.push_back(mk("done_hold2",     0,1,0,0,0, 27'h300,16'h10, 1,0,2'b00,3'b000,2'd2, 27'h300,16'h10));
    tbl.push_back(mk("done_release",   0,0,0,0,0, 27'h300,16'h10, 1,0,2'b00,3'b000,2'd2, 27'h300,16'h10));
    tbl.push_back(mk("idle_again",     0,0,0,0,1, 27'h300,16'h10, 0,0,2'b00,3'b000,2'd0, 27'h300,16'h10));
    tbl.push_back(mk("idle_req2",      0,1,0,0,0, 27'h100,16'h40, 0,0,2'b00,3'b000,2'd0, 27'h300,16'h10));
    tbl.push_back(mk("load2_p0",       0,1,0,0,0, 27'h100,16'h40, 1,0,2'b10,3'b000,2'd0, 27'h300,16'h10));
    tbl.push_back(mk("req2_p0_both",   0,1,1,1,0, 27'h200,16'h20, 1,1,2'b10,3'b000,2'd0, 27'h100,16'h40));
    tbl.push_back(mk("load2_p1",       0,1,0,0,0, 27'h200,16'h20, 1,0,2'b01,3'b000,2'd1, 27'h100,16'h40));
    tbl.push_back(mk("req2_p1_rrdy",   0,1,1,0,0, 27'h200,16'h20, 1,1,2'b01,3'b000,2'd1, 27'h200,16'h20));
    tbl.push_back(mk("rst_mid_data",   1,1,0,0,1, 27'h200,16'h20, 0,0,2'b00,3'b000,2'd0, 27'h0,  16'h0));
    tbl.push_back(mk("post_rst_req",   0,1,0,0,1, 27'h100,16'h40, 0,0,2'b00,3'b000,2'd0, 27'h0,  16'h0));
    tbl.push_back(mk("post_rst_load",  0,1,0,0,1, 27'h100,16'h40, 1,0,2'b10,3'b000,2'd0, 27'h0,  16'h0));
    tbl.push_back(mk("rst_again",      1,0,0,0,0, 27'h0,  16'h0,  0,0,2'b00,3'b000,2'd0, 27'h0,  16'h0));

    repeat (2) @(posedge ddr_clk);
    #1;
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].lreq, tbl[i].rrdy, tbl[i].rdone, tbl[i].rde, tbl[i].addr, tbl[i].len);
      #1;
      chk(tbl[i].name, got_v, {1'b0, tbl[i].busy, tbl[i].rreq, tbl[i].op, tbl[i].rden,
                               tbl[i].idx, tbl[i].raddr, tbl[i].rlen});
      @(posedge ddr_clk);
      #1;
    end

    // Randomised traffic against the model (reset still asserted from the last table row)
    m_reset();
    for (int i = 0; i < 600; i++) begin
      mstep($sformatf("rand%0d", i),
            $urandom_range(0, 79) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
            AW'($urandom), LW'($urandom));
    end

    // Long wait in REQ with no controller response
    mstep("lw_rst", 1, 0, 0, 0, 0, 27'h0, 16'h0);
    for (int i = 0; i < 14; i++) begin
      mstep($sformatf("long_wait%0d", i), 0, 1, 0, 0, 1, 27'h0abc, 16'h0123);
    end
    drive(0, 1, 0, 0, 0, 27'h0abc, 16'h0123);
    #1;
    chk("long_wait_status", {29'h0, got_v[OW-1 -: 3]}, {29'h0, LONG_WAIT_EXP});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
